// File: rtl/enc_store_engine.sv
// enc_store_engine: rotate-then-multiply encryptor with an auto-addressed
// result memory. Operands arrive over a valid/ready handshake. Each operand is
// rotated right by ROT mod WIDTH, then multiplied by the key using a
// WIDTH-cycle shift-add multiplier. The product is stored at wr_ptr.
// Optional feature macro: ENC_FULL_STALL_EN stalls input once DEPTH results
// are held, instead of overwriting the oldest entries.
module enc_store_engine #(
    parameter int WIDTH  = 4,
    parameter int ROT    = 2,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    num,
    input  logic [WIDTH-1:0]    key,
    input  logic                clear,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   wr_ptr,
    output logic [ADDR_W:0]     count,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [2*WIDTH-1:0]  rd_data
);

    localparam int RS = ROT % WIDTH;
    localparam int KW = $clog2(WIDTH + 1);
    localparam logic [KW-1:0]   K_LAST = KW'(WIDTH - 1);
    localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROT   = 2'd1;
    localparam logic [1:0] S_MULT  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    logic [1:0]         state;
    logic [WIDTH-1:0]   num_r;
    logic [WIDTH-1:0]   key_r;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   q;
    logic [KW-1:0]      k;
    logic [2*WIDTH-1:0] rot_dbl;
    logic [WIDTH:0]     sum;
    logic               accept;
    logic               store;
    logic [2*WIDTH-1:0] mem [DEPTH];

    assign busy  = (state != S_IDLE);
    assign store = (state == S_STORE);

`ifdef ENC_FULL_STALL_EN
    assign in_ready = (state == S_IDLE) && (count < FULL);
`else
    assign in_ready = (state == S_IDLE);
`endif

    assign accept  = in_valid && in_ready;
    assign rot_dbl = {num_r, num_r} >> RS;
    // The carry register is folded into sum[WIDTH]; it is shifted straight into A.
    assign sum     = {1'b0, a} + (q[0] ? {1'b0, m} : '0);
    assign rd_data = mem[rd_addr];

    // Control FSM plus the rotate/multiply datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            num_r <= '0;
            key_r <= '0;
            m     <= '0;
            a     <= '0;
            q     <= '0;
            k     <= '0;
            done  <= 1'b0;
        end else begin
            done <= store;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        num_r <= num;
                        key_r <= key;
                        state <= S_ROT;
                    end
                end
                S_ROT: begin
                    m     <= rot_dbl[WIDTH-1:0];
                    a     <= '0;
                    q     <= key_r;
                    k     <= '0;
                    state <= S_MULT;
                end
                S_MULT: begin
                    a <= sum[WIDTH:1];
                    q <= {sum[0], q[WIDTH-1:1]};
                    k <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= S_STORE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Write pointer and fill count; clear overrides any same-cycle store.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (store) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end
    end

    // Result memory, zeroed by reset, written once per completed operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store) begin
            mem[wr_ptr] <= {a, q};
        end
    end

endmodule

// File: tb/tb_enc_store_engine.sv
// Scoreboard bench for enc_store_engine: the driver pushes expected products,
// and a monitor pops them on each done pulse and checks memory, pointers and latency.
module tb_enc_store_engine;

    localparam int W   = 4;
    localparam int ROT = 2;
    localparam int D   = 16;
    localparam int AW  = 4;
    localparam int LAT = W + 3;

    typedef struct {
        int prod;
        int acc;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  num;
    logic [W-1:0]  key;
    logic          clear;
    logic          busy;
    logic          done;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW-1:0] rd_addr;
    logic [2*W-1:0] rd_data;

    int   checks;
    int   fails;
    int   cyc;
    exp_t exp_q[$];
    int   m_mem[D];
    int   m_wp;
    int   m_cnt;
    bit   prev_done;
    exp_t mon_e;
    int   mon_addr;

    enc_store_engine #(.WIDTH(W), .ROT(ROT), .DEPTH(D), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .num(num), .key(key), .clear(clear), .busy(busy), .done(done),
        .wr_ptr(wr_ptr), .count(count), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int model_prod(input int n, input int k);
        int r;
        int rn;
        r  = ROT % W;
        rn = ((n >> r) | (n << (W - r))) & ((1 << W) - 1);
        return rn * k;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned expv);
        checks++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: each done pulse retires the oldest expected result.
    always @(negedge clock) begin
        if (done) begin
            check("done_width", prev_done, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_addr = m_wp;
                m_mem[mon_addr] = mon_e.prod;
                m_wp = (m_wp + 1) % D;
                if (m_cnt < D) m_cnt++;
                rd_addr = AW'(mon_addr);
                #1;
                check("store_data", rd_data, mon_e.prod);
                check("wr_ptr", wr_ptr, m_wp);
                check("count", count, m_cnt);
                check("latency", cyc - mon_e.acc, LAT);
                check("busy_after", busy, 0);
            end
        end
        prev_done = done;
    end

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        m_wp  = 0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic send(input int n, input int k, input bit keep, output int acc);
        bit ok;
        ok  = 1'b0;
        acc = -1;
        @(negedge clock);
        num      = W'(n);
        key      = W'(k);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok  = 1'b1;
                acc = cyc;
                exp_q.push_back('{model_prod(n, k), cyc});
                break;
            end
            @(negedge clock);
        end
        check("accept_timeout", ok, 1);
        if (ok) begin
            @(posedge clock);
            #1;
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy && !done && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
        check("idle_timeout", ok, 1);
    endtask

    task automatic check_mem();
        for (int i = 0; i < D; i++) begin
            rd_addr = AW'(i);
            #1;
            check("mem_readback", rd_data, m_mem[i]);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        m_wp  = 0;
        m_cnt = 0;
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        int acc;
        int acc_prev;
        int seen;
        int nrand;
        checks   = 0;
        fails    = 0;
        cyc      = 0;
        prev_done = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        num      = '0;
        key      = '0;
        rd_addr  = '0;
        model_reset();

        // Reset values.
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_count", count, 0);
        check_mem();

        // Directed vectors from the plan, plus extremes.
        send(4'b1000, 4'b1000, 0, acc);
        send(4'b1001, 4'b1000, 0, acc);
        send(4'b1100, 4'b1010, 0, acc);
        send(4'b1011, 4'b1110, 0, acc);
        wait_idle();
        rd_addr = 0; #1; check("vec0", rd_data, 8'h10);
        rd_addr = 1; #1; check("vec1", rd_data, 8'h30);
        rd_addr = 2; #1; check("vec2", rd_data, 8'h1E);
        rd_addr = 3; #1; check("vec3", rd_data, 8'hC4);
        check("vec_count", count, 4);
        check("vec_wr_ptr", wr_ptr, 4);
        send(4'b1111, 4'b1111, 0, acc);
        send(4'b0110, 4'b0000, 0, acc);
        wait_idle();
        rd_addr = 4; #1; check("vec_max", rd_data, 8'hE1);
        rd_addr = 5; #1; check("vec_zero_key", rd_data, 8'h00);

        // Continuous in_valid: accepts spaced by the full latency.
        do_reset();
        acc_prev = -1;
        for (int i = 0; i < 4; i++) begin
            send($urandom_range(0, 15), $urandom_range(0, 15), (i != 3), acc);
            if (acc_prev >= 0) check("accept_spacing", acc - acc_prev, LAT);
            acc_prev = acc;
        end
        wait_idle();
        check_mem();

        // Seventeen operands: wrap or stall depending on build.
        do_reset();
        for (int i = 0; i < 16; i++) send(4'b1000, i, 0, acc);
        wait_idle();
        check("full_count", count, 16);
`ifdef ENC_FULL_STALL_EN
        check("full_in_ready", in_ready, 0);
        @(negedge clock);
        num      = 4'b1000;
        key      = 4'b0000;
        in_valid = 1'b1;
        seen     = 0;
        repeat (8) begin
            @(negedge clock);
            if (in_ready || busy) seen++;
        end
        check("full_stall", seen, 0);
        in_valid = 1'b0;
        pulse_clear();
        send(4'b1000, 16 % 16, 0, acc);
        wait_idle();
        check("stall_wr_ptr", wr_ptr, 1);
        check("stall_count", count, 1);
`else
        send(4'b1000, 16 % 16, 0, acc);
        wait_idle();
        check("wrap_count", count, 16);
        check("wrap_wr_ptr", wr_ptr, 1);
`endif
        check_mem();

        // Reset three cycles into an operation aborts it.
        do_reset();
        send(4'b0111, 4'b0101, 0, acc);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_wr_ptr", wr_ptr, 0);
        check("abort_count", count, 0);
        rd_addr = 0; #1; check("abort_mem0", rd_data, 0);

        // Clear during MULT of an operation started at wr_ptr=5.
        do_reset();
        for (int i = 0; i < 5; i++) send($urandom_range(0, 15), $urandom_range(0, 15), 0, acc);
        wait_idle();
        check("pre_clear_wr_ptr", wr_ptr, 5);
        send(4'b1011, 4'b0111, 0, acc);
        @(negedge clock);
        pulse_clear();
        wait_idle();
        check("clr_wr_ptr", wr_ptr, 1);
        check("clr_count", count, 1);
        rd_addr = 0; #1; check("clr_mem0", rd_data, 8'h62);

        // Randomized traffic against the reference model.
        do_reset();
`ifdef ENC_FULL_STALL_EN
        nrand = 12;
`else
        nrand = 25;
`endif
        for (int i = 0; i < nrand; i++) begin
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), acc);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        in_valid = 1'b0;
        wait_idle();
        check_mem();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
